pc_fetch_ctrl: RTL and testbench

//  Program-counter / fetch-sequencing stage. Consumes the 10-bit branch Target produced by the

---
 rtl/pc_fetch_ctrl.sv | 109 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Program-counter and fetch-sequencing stage. It takes the branch target or
//   offset from the lookup table and drives ProgCtr into the instruction ROM.
//   A four-state run-control FSM (IDLE/ARMED/RUN/DONE) gates all sequencing.
//   Two counters are kept for the bench: cycles spent in RUN, and taken
//   branches executed in RUN. Both counters saturate instead of wrapping.
// Ports
//   Clk          in   system clock, rising edge
//   Reset_n      in   asynchronous active-low reset
//   Start        in   level: hold/arm at START_ADDR; the falling edge launches a run
//   BranchEn     in   decoded instruction is a branch
//   Taken        in   branch condition is true
//   AbsJump      in   1: Target is an absolute address, 0: Target is a signed offset
//   Target       in   branch target or offset [PC_W]
//   Halt         in   decoded instruction is the program-end opcode
//   ProgCtr      out  fetch address [PC_W]
//   Busy         out  high in RUN
//   Done         out  high in DONE
//   CycleCount   out  cycles spent in RUN [CNT_W]
//   BranchCount  out  taken branches executed in RUN [CNT_W]
module pc_fetch_ctrl #(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int              CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             BranchEn,
    input  logic             Taken,
    input  logic             AbsJump,
    input  logic [PC_W-1:0]  Target,
    input  logic             Halt,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount,
    output logic [CNT_W-1:0] BranchCount
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);

    state_t           state, state_nx;
    logic [PC_W-1:0]  pc_nx;
    logic [CNT_W-1:0] cyc_nx, br_nx;

    // Busy/Done come straight from the state register, so they are glitch-free
    // and change on the same edge as ProgCtr.
    assign Busy = (state == S_RUN);
    assign Done = (state == S_DONE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            ProgCtr     <= START_ADDR;
            CycleCount  <= '0;
            BranchCount <= '0;
        end else begin
            state       <= state_nx;
            ProgCtr     <= pc_nx;
            CycleCount  <= cyc_nx;
            BranchCount <= br_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = ProgCtr;
        cyc_nx   = CycleCount;
        br_nx    = BranchCount;
        if (Start) begin
            // Start overrides everything, including a halt in the same cycle.
            state_nx = S_ARMED;
            pc_nx    = START_ADDR;
            cyc_nx   = '0;
            br_nx    = '0;
        end else begin
            unique case (state)
                // ProgCtr already sits at START_ADDR, so the first RUN fetch uses it.
                S_ARMED: state_nx = S_RUN;
                S_RUN: begin
                    cyc_nx = (CycleCount == CNT_MAX) ? CycleCount : CycleCount + CNT_ONE;
                    if (Halt) begin
                        // ProgCtr stays on the halt instruction; the branch is dropped.
                        state_nx = S_DONE;
                    end else if (BranchEn && Taken) begin
                        // Relative targets are two's complement; the same-width add
                        // wraps modulo 2^PC_W, which gives the signed offset for free.
                        pc_nx = AbsJump ? Target : ProgCtr + Target;
                        br_nx = (BranchCount == CNT_MAX) ? BranchCount : BranchCount + CNT_ONE;
                    end else begin
                        pc_nx = ProgCtr + PC_ONE;
                    end
                end
                default: ; // IDLE and DONE hold until Start
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic        BranchEn = 1'b0;
    logic        Taken = 1'b0;
    logic        AbsJump = 1'b0;
    logic [9:0]  Target = '0;
    logic        Halt = 1'b0;
    logic [9:0]  ProgCtr;
    logic        Busy;
    logic        Done;
    logic [15:0] CycleCount;
    logic [15:0] BranchCount;

    int total = 0;
    int bad   = 0;

    pc_fetch_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .BranchEn(BranchEn),
        .Taken(Taken), .AbsJump(AbsJump), .Target(Target), .Halt(Halt),
        .ProgCtr(ProgCtr), .Busy(Busy), .Done(Done),
        .CycleCount(CycleCount), .BranchCount(BranchCount)
    );

    always #5 Clk = ~Clk;

    // Behavioural model: flags for the run phase and plain integers with
    // explicit modulo and min() arithmetic.
    int m_pc, m_cyc, m_br;
    bit m_armed, m_run, m_done;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_pc = 0; m_cyc = 0; m_br = 0;
            m_armed = 0; m_run = 0; m_done = 0;
        end else if (Start) begin
            m_pc = 0; m_cyc = 0; m_br = 0;
            m_armed = 1; m_run = 0; m_done = 0;
        end else if (m_armed) begin
            m_armed = 0; m_run = 1;
        end else if (m_run) begin
            m_cyc = (m_cyc + 1 > 65535) ? 65535 : m_cyc + 1;
            if (Halt) begin
                m_run = 0; m_done = 1;
            end else if (BranchEn && Taken) begin
                m_pc = AbsJump ? int'(Target) : (m_pc + int'(Target)) % 1024;
                m_br = (m_br + 1 > 65535) ? 65535 : m_br + 1;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model, away from the active edge.
    always @(negedge Clk) begin
        chk("model_pc",   int'(ProgCtr),     m_pc);
        chk("model_busy", int'(Busy),        int'(m_run));
        chk("model_done", int'(Done),        int'(m_done));
        chk("model_cyc",  int'(CycleCount),  m_cyc);
        chk("model_br",   int'(BranchCount), m_br);
    end

    task automatic cyc(input logic br, input logic tk, input logic ab,
                       input logic [9:0] tg, input logic hl);
        BranchEn = br; Taken = tk; AbsJump = ab; Target = tg; Halt = hl;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
    endtask

    task automatic jump_abs(input logic [9:0] tg);
        cyc(1'b1, 1'b1, 1'b1, tg, 1'b0);
    endtask

    task automatic launch();
        Start = 1'b1;
        idle_cyc();
        Start = 1'b0;
        idle_cyc();
    endtask

    initial begin
        @(negedge Clk);
        @(negedge Clk);
        chk("reset_pc",   int'(ProgCtr), 0);
        chk("reset_busy", int'(Busy), 0);
        chk("reset_done", int'(Done), 0);
        chk("reset_cyc",  int'(CycleCount), 0);
        Reset_n = 1'b1;

        // IDLE ignores branch/halt inputs
        cyc(1'b1, 1'b1, 1'b1, 10'h155, 1'b1);
        chk("idle_pc",   int'(ProgCtr), 0);
        chk("idle_busy", int'(Busy), 0);

        // Test 1: Start two cycles, then run sequentially
        Start = 1'b1;
        idle_cyc();
        chk("armed_busy", int'(Busy), 0);
        idle_cyc();
        Start = 1'b0;
        idle_cyc();
        chk("run_first_pc", int'(ProgCtr), 0);
        chk("run_busy",     int'(Busy), 1);
        for (int i = 1; i <= 4; i++) begin
            idle_cyc();
            chk("seq_pc", int'(ProgCtr), i);
        end
        chk("seq_cyc", int'(CycleCount), 4);

        // Test 2: walk to 0x020, absolute jump to 0x098
        for (int i = 0; i < 28; i++) idle_cyc();
        chk("walk_pc", int'(ProgCtr), 'h020);
        jump_abs(10'h098);
        chk("abs_pc", int'(ProgCtr), 'h098);
        chk("abs_br", int'(BranchCount), 1);

        // Test 3: relative -16 from 0x0C3, then not-taken from 0x0C3
        jump_abs(10'h0C3);
        cyc(1'b1, 1'b1, 1'b0, 10'h3F0, 1'b0);
        chk("rel_neg_pc", int'(ProgCtr), 'h0B3);
        chk("rel_neg_br", int'(BranchCount), 3);
        jump_abs(10'h0C3);
        cyc(1'b1, 1'b0, 1'b0, 10'h3F0, 1'b0);
        chk("not_taken_pc", int'(ProgCtr), 'h0C4);
        chk("not_taken_br", int'(BranchCount), 4);

        // Test 4: wraparound, sequential and relative
        jump_abs(10'h3FF);
        idle_cyc();
        chk("wrap_seq_pc", int'(ProgCtr), 'h000);
        jump_abs(10'h3FF);
        cyc(1'b1, 1'b1, 1'b0, 10'h002, 1'b0);
        chk("wrap_rel_pc", int'(ProgCtr), 'h001);

        // Test 5: halt beats a taken branch
        jump_abs(10'h112);
        chk("pre_halt_br", int'(BranchCount), 8);
        chk("pre_halt_cyc", int'(CycleCount), 42);
        cyc(1'b1, 1'b1, 1'b1, 10'h200, 1'b1);
        chk("halt_pc",   int'(ProgCtr), 'h112);
        chk("halt_done", int'(Done), 1);
        chk("halt_busy", int'(Busy), 0);
        chk("halt_br",   int'(BranchCount), 8);
        chk("halt_cyc",  int'(CycleCount), 43);
        cyc(1'b1, 1'b1, 1'b1, 10'h055, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
        chk("done_hold_pc",  int'(ProgCtr), 'h112);
        chk("done_hold_cyc", int'(CycleCount), 43);
        Start = 1'b1;
        idle_cyc();
        chk("rearm_pc",   int'(ProgCtr), 0);
        chk("rearm_done", int'(Done), 0);
        chk("rearm_cyc",  int'(CycleCount), 0);
        chk("rearm_br",   int'(BranchCount), 0);
        Start = 1'b0;
        idle_cyc();

        // Test 6: async reset between edges
        idle_cyc();
        idle_cyc();
        chk("pre_rst_pc", int'(ProgCtr), 2);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_pc",   int'(ProgCtr), 0);
        chk("async_rst_busy", int'(Busy), 0);
        chk("async_rst_cyc",  int'(CycleCount), 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Counter saturation
        launch();
        for (int i = 0; i < 65534; i++) idle_cyc();
        chk("cyc_max_m1", int'(CycleCount), 'hFFFE);
        for (int i = 0; i < 3; i++) begin
            idle_cyc();
            chk("cyc_sat", int'(CycleCount), 'hFFFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
